credit_rate_limiter: RTL
========================

Name: credit_rate_limiter

Overview:
- Downstream consumer of the fractional counter's wrap pulse.
- Converts each qualified wrap (`ena & wrp`) into one transfer credit and uses those credits to gate a valid/ready stream.
- Produces a long-term average throughput of `tck` rate beats per cycle, with bursts of up to `cap` beats.
- Sits between a data source and a rate-sensitive sink (UART/DAC sample pacing); one registered output stage.

Parameters:
- WIDTH, 4, width of credit counter and `cap` port.
- DW, 8, stream data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- tck  input  1  credit tick; one credit per cycle where `tck`=1 (driven by `ena & wrp` of the counter).
- cap  input  WIDTH  credit ceiling (burst size); quasi-static.
- s_vld  input  1  upstream valid.
- s_rdy  output  1  upstream ready.
- s_dat  input  DW  upstream data.
- m_vld  output  1  downstream valid (registered).
- m_rdy  input  1  downstream ready.
- m_dat  output  DW  downstream data (registered).
- crd  output  WIDTH  current credit count (registered).
- ovf  output  1  registered one-cycle pulse: a tick was discarded at saturation.

Behaviour:
- Reset (`rst`=0, async): `crd`=0, `m_vld`=0, `m_dat`=0, `ovf`=0. Release is synchronous to `clk` from the system reset synchronizer.
- `s_rdy` (combinational) = (`crd` != 0) & (!`m_vld` | `m_rdy`). It does not depend on `s_vld`, and a same-cycle `tck` does not count; only registered credit is spendable.
- Accept = `s_vld` & `s_rdy`. On accept: `m_dat` <= `s_dat`, `m_vld` <= 1.
- Drain = `m_vld` & `m_rdy`. On drain without accept: `m_vld` <= 0. Drain and accept in the same cycle: `m_vld` stays 1 with new data (zero-bubble).
- `m_vld`/`m_dat` hold stable while `m_vld`=1 and `m_rdy`=0.
- Credit update per cycle (inc=`tck`, dec=accept):
  - inc&!dec: `crd`+1 if `crd` < `cap`; else hold and `ovf` <= 1.
  - !inc&dec: `crd`-1. `crd`>0 is guaranteed by `s_rdy`.
  - inc&dec: hold. No `ovf`, even if `crd`==`cap`.
  - neither: hold.
- `ovf` is 0 in every cycle not listed above.
- Lowering `cap`: if `crd` > `cap`, then `crd` <= `cap` next cycle (clamp takes priority over inc/dec). A tick in that cycle sets `ovf`.
- `cap`=0: `crd` stays 0, `s_rdy`=0 permanently, and every tick pulses `ovf`.
- Counter arithmetic is WIDTH-bit unsigned. The compare `crd` < `cap` prevents wrap past 2**WIDTH-1.
- Latency: input to output is 1 cycle; a tick becomes spendable 1 cycle after it is sampled.
- Reset asserted mid-transfer: in-flight `m_dat` is discarded, `m_vld` drops immediately (async), and credits are lost.

Optional Feature:
- Macro: CREDIT_RATE_LIMITER_STATS_EN.
- Defined:
  - Adds output `drp` [WIDTH-1:0]: count of discarded ticks (`ovf` events) and of stalled cycles (`s_vld`=1, `crd`=0) combined.
  - Saturates at 2**WIDTH-1.
  - Reset to 0; cleared by input `clr` (1 bit, synchronous). When `clr` and an event coincide, `drp` <= 0.
- Undefined: no `drp`/`clr` ports and no counter logic. All other behaviour is identical.

Test Plan:
- Reset/idle: hold `rst`=0 4 cycles with `tck`=1 and `s_vld`=1 → `crd`=0, `m_vld`=0, `s_rdy`=0, `ovf`=0. After release, `crd` increments 1 per cycle to `cap`.
- Saturation: `cap`=3, `tck`=1 continuous, `s_vld`=0 → `crd` = 1, 2, 3, 3…; `ovf`=1 on every cycle after reaching 3.
- Paced stream: `tck` pulse every 5 cycles, `cap`=1, `s_vld`=1 continuous, `m_rdy`=1, `s_dat` incrementing from 0x00 → `m_dat` 0x00, 0x01, … each valid for exactly 1 cycle, 5 cycles apart, with no duplicates or gaps in sequence.
- Burst and backpressure: `cap`=15, pre-load 4 credits, `s_vld`=1, `m_rdy` pattern 1,0,0,1,1,1 → exactly 4 beats delivered in order. `m_dat` is stable during the `m_rdy`=0 cycles, then `crd`=0 and `s_rdy`=0.
- Simultaneous tick/accept at full: `cap`=2, `crd`=2, `tck`=1 plus accept in the same cycle → `crd` stays 2, `ovf`=0.
- `cap` edge cases: with `crd`=7, drive `cap`=2 → `crd`=2 next cycle. Drive `cap`=0 → `crd`=0, `s_rdy`=0, and each tick pulses `ovf`. Randomized `tck`/`s_vld`/`m_rdy` for 2**WIDTH+2 ticks compared against a scoreboard credit model.

Source files
------------

// File: rtl/credit_rate_limiter.sv
`default_nettype none
// ============================================================================
// Module      : credit_rate_limiter
// Description : Credit-gated valid/ready stage. Each tick earns one credit
//               (up to cap); each accepted beat spends one. Registered output.
//               Optional macro CREDIT_RATE_LIMITER_STATS_EN adds clr/drp stats.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_rate_limiter #(
  parameter int WIDTH = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic [WIDTH-1:0] cap,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [DW-1:0]    s_dat,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [DW-1:0]    m_dat,
  output logic [WIDTH-1:0] crd,
  output logic             ovf
`ifdef CREDIT_RATE_LIMITER_STATS_EN
  ,
  input  logic             clr,
  output logic [WIDTH-1:0] drp
`endif
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] crd_q, crd_d;
  logic             m_vld_q, m_vld_d;
  logic [DW-1:0]    m_dat_q, m_dat_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             drain;

  always_comb begin
    // Only registered credit is spendable; a same-cycle tick cannot be used.
    s_rdy  = (crd_q != '0) && (!m_vld_q || m_rdy);
    accept = s_vld && s_rdy;
    drain  = m_vld_q && m_rdy;

    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    if (accept) begin
      m_vld_d = 1'b1;
      m_dat_d = s_dat;
    end else if (drain) begin
      m_vld_d = 1'b0;
    end

    crd_d = crd_q;
    ovf_d = 1'b0;
    if (crd_q > cap) begin
      // A lowered ceiling wins over this cycle's earn/spend.
      crd_d = cap;
      ovf_d = tck;
    end else if (tck && !accept) begin
      if (crd_q < cap) begin
        crd_d = crd_q + c_one;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (!tck && accept) begin
      crd_d = crd_q - c_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crd_q   <= '0;
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      crd_q   <= crd_d;
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign crd   = crd_q;
  assign m_vld = m_vld_q;
  assign m_dat = m_dat_q;
  assign ovf   = ovf_q;

`ifdef CREDIT_RATE_LIMITER_STATS_EN
  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] drp_q, drp_d;
  logic             stall;
  logic [WIDTH:0]   drp_sum;

  always_comb begin
    stall   = s_vld && (crd_q == '0);
    // A discarded tick and a stall in the same cycle count as two events.
    drp_sum = {1'b0, drp_q} + {{WIDTH{1'b0}}, ovf_d} + {{WIDTH{1'b0}}, stall};
    if (clr) begin
      drp_d = '0;
    end else if (drp_sum > {1'b0, c_max}) begin
      drp_d = c_max;
    end else begin
      drp_d = drp_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drp_q <= '0;
    end else begin
      drp_q <= drp_d;
    end
  end

  assign drp = drp_q;
`endif

endmodule
`default_nettype wire
